// File: rtl/smi_mem_lib_framer_pkg.sv
// Shared types and sizing helpers for the write stream framer.
// The FSM state encoding and counter widths live here so the top and any bench agree on them.
package smi_mem_lib_framer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_ISSUE,
        ST_DRAIN,
        ST_FLUSH,
        ST_REPORT
    } state_e;

    localparam int OUT_W = 4;

    // Wide enough to hold the value MaxBurstLen itself, not just MaxBurstLen-1.
    function automatic int count_width(input int max_burst_len);
        return $clog2(max_burst_len) + 1;
    endfunction

endpackage

// File: rtl/smi_mem_lib_framer_fifo.sv
// Synchronous FIFO holding one burst of stream words between Fill and Drain.
// Depth must be a power of two so the pointers wrap naturally.
module smi_mem_lib_framer_fifo
    import smi_mem_lib_framer_pkg::*;
#(
    parameter int Depth = 256,
    parameter int Width = 64
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push_valid_i,
    input  logic [Width-1:0] push_data_i,
    output logic             push_stop_o,
    output logic             pop_valid_o,
    output logic [Width-1:0] pop_data_o,
    input  logic             pop_stop_i
);

    localparam int AW = $clog2(Depth);
    localparam int CW = count_width(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_fire;
    logic             pop_fire;

    assign push_stop_o = (count_q == CW'(Depth));
    assign pop_valid_o = (count_q != '0);
    assign pop_data_o  = mem_q[rd_ptr_q];
    assign push_fire   = push_valid_i && !push_stop_o;
    assign pop_fire    = pop_valid_o && !pop_stop_i;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_fire) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_fire)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push_fire) - CW'(pop_fire);
        end
    end

    // NOTE: the storage array has no reset; only the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_fire) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/smi_mem_lib_write_stream_framer.sv
// Splits an EOS-terminated 64-bit stream into bounded write bursts, tracks outstanding
// bursts against the writer's completions and reports one aggregated status per stream.
module smi_mem_lib_write_stream_framer
    import smi_mem_lib_framer_pkg::*;
#(
    parameter int MaxBurstLen    = 256,
    parameter int MaxOutstanding = 15
) (
    input  logic        clk,
    input  logic        srst,

    input  logic        cfgValid,
    input  logic [63:0] cfgBaseAddr,
    input  logic [7:0]  cfgOpts,
    output logic        cfgStop,

    input  logic        streamValid,
    input  logic [63:0] streamData,
    input  logic        streamEos,
    output logic        streamStop,

    output logic        burstValid,
    output logic [63:0] burstAddr,
    output logic [31:0] burstLen,
    output logic [7:0]  burstOpts,
    input  logic        burstStop,

    output logic        writeValid,
    output logic [63:0] writeData,
    input  logic        writeStop,

    input  logic        doneValid,
    input  logic        doneStatusOk,
    output logic        doneStop,

    output logic        resultValid,
    output logic        resultStatusOk,
    output logic [31:0] resultWords,
    input  logic        resultStop
);

    localparam int CW = count_width(MaxBurstLen);

    state_e            state_q;
    logic [63:0]       addr_q;
    logic [7:0]        opts_q;
    logic [CW-1:0]     burst_count_q;
    logic [OUT_W-1:0]  outstanding_q;
    logic [OUT_W-1:0]  outstanding_d;
    logic [31:0]       word_total_q;
    logic              status_ok_q;
    logic              last_q;

    logic              cfg_fire;
    logic              stream_fire;
    logic              burst_fire;
    logic              write_fire;
    logic              result_fire;
    logic              done_take;

    logic              fifo_push_valid;
    logic              fifo_full;
    logic              fifo_pop_valid;
    logic              fifo_pop_stop;
    logic [63:0]       fifo_pop_data;

    // Address bits [2:0] are forced to zero on latch, so the low cfg bits are intentionally dropped.
    logic              unused_addr_lsbs;
    assign unused_addr_lsbs = ^cfgBaseAddr[2:0];

    assign fifo_push_valid = streamValid && (state_q == ST_FILL);
    assign fifo_pop_stop   = writeStop || (state_q != ST_DRAIN);

    smi_mem_lib_framer_fifo #(
        .Depth (MaxBurstLen),
        .Width (64)
    ) u_fifo (
        .clk          (clk),
        .srst         (srst),
        .push_valid_i (fifo_push_valid),
        .push_data_i  (streamData),
        .push_stop_o  (fifo_full),
        .pop_valid_o  (fifo_pop_valid),
        .pop_data_o   (fifo_pop_data),
        .pop_stop_i   (fifo_pop_stop)
    );

    assign cfgStop        = (state_q != ST_IDLE);
    assign streamStop     = (state_q != ST_FILL) || fifo_full;
    assign burstValid     = (state_q == ST_ISSUE) && (outstanding_q < OUT_W'(MaxOutstanding));
    assign burstAddr      = addr_q;
    assign burstLen       = 32'(burst_count_q);
    assign burstOpts      = opts_q;
    assign writeValid     = (state_q == ST_DRAIN) && fifo_pop_valid;
    assign writeData      = writeValid ? fifo_pop_data : '0;
    assign doneStop       = 1'b0;
    assign resultValid    = (state_q == ST_REPORT);
    assign resultStatusOk = status_ok_q;
    assign resultWords    = word_total_q;

    assign cfg_fire    = cfgValid && !cfgStop;
    assign stream_fire = streamValid && !streamStop;
    assign burst_fire  = burstValid && !burstStop;
    assign write_fire  = writeValid && !writeStop;
    assign result_fire = resultValid && !resultStop;
    // Completions arriving with nothing outstanding (e.g. stale ones after a reset) are dropped.
    assign done_take   = doneValid && (outstanding_q != '0);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        outstanding_d = outstanding_q;
        unique case ({burst_fire, done_take})
            2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
            2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!srst) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            opts_q        <= '0;
            burst_count_q <= '0;
            outstanding_q <= '0;
            word_total_q  <= '0;
            status_ok_q   <= 1'b0;
            last_q        <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
            if (done_take) status_ok_q <= status_ok_q & doneStatusOk;

            case (state_q)
                ST_IDLE: begin
                    if (cfg_fire) begin
                        addr_q       <= {cfgBaseAddr[63:3], 3'b000};
                        opts_q       <= cfgOpts;
                        word_total_q <= '0;
                        status_ok_q  <= 1'b1;
                        state_q      <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (stream_fire) begin
                        burst_count_q <= burst_count_q + CW'(1);
                        if (streamEos) last_q <= 1'b1;
                        if (streamEos || (burst_count_q == CW'(MaxBurstLen - 1))) begin
                            state_q <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (burst_fire) begin
                        addr_q       <= addr_q + (64'(burst_count_q) << 3);
                        word_total_q <= word_total_q + 32'(burst_count_q);
                        state_q      <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Counting down to zero both tracks the remaining words and clears the count.
                    if (write_fire) begin
                        burst_count_q <= burst_count_q - CW'(1);
                        if (burst_count_q == CW'(1)) begin
                            state_q <= last_q ? ST_FLUSH : ST_FILL;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (outstanding_q == '0) state_q <= ST_REPORT;
                end
                ST_REPORT: begin
                    if (result_fire) begin
                        last_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_smi_mem_lib_write_stream_framer.sv
// Scoreboard bench: stimulus pushes expected bursts, words and results; a negedge monitor checks them.
// Instance 0 uses MaxBurstLen=4/MaxOutstanding=1, instance 1 uses the 256/15 defaults.
module tb_smi_mem_lib_write_stream_framer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        srst         [2];
    logic        cfg_valid    [2];
    logic [63:0] cfg_base     [2];
    logic [7:0]  cfg_opts     [2];
    logic        cfg_stop     [2];
    logic        stream_valid [2];
    logic [63:0] stream_data  [2];
    logic        stream_eos   [2];
    logic        stream_stop  [2];
    logic        burst_valid  [2];
    logic [63:0] burst_addr   [2];
    logic [31:0] burst_len    [2];
    logic [7:0]  burst_opts   [2];
    logic        burst_stop   [2];
    logic        write_valid  [2];
    logic [63:0] write_data   [2];
    logic        write_stop   [2];
    logic        done_valid   [2];
    logic        done_ok      [2];
    logic        done_stop    [2];
    logic        result_valid [2];
    logic        result_ok    [2];
    logic [31:0] result_words [2];
    logic        result_stop  [2];

    smi_mem_lib_write_stream_framer #(.MaxBurstLen(4), .MaxOutstanding(1)) u_dut_small (
        .clk(clk), .srst(srst[0]),
        .cfgValid(cfg_valid[0]), .cfgBaseAddr(cfg_base[0]), .cfgOpts(cfg_opts[0]), .cfgStop(cfg_stop[0]),
        .streamValid(stream_valid[0]), .streamData(stream_data[0]), .streamEos(stream_eos[0]),
        .streamStop(stream_stop[0]),
        .burstValid(burst_valid[0]), .burstAddr(burst_addr[0]), .burstLen(burst_len[0]),
        .burstOpts(burst_opts[0]), .burstStop(burst_stop[0]),
        .writeValid(write_valid[0]), .writeData(write_data[0]), .writeStop(write_stop[0]),
        .doneValid(done_valid[0]), .doneStatusOk(done_ok[0]), .doneStop(done_stop[0]),
        .resultValid(result_valid[0]), .resultStatusOk(result_ok[0]), .resultWords(result_words[0]),
        .resultStop(result_stop[0])
    );

    smi_mem_lib_write_stream_framer #(.MaxBurstLen(256), .MaxOutstanding(15)) u_dut_large (
        .clk(clk), .srst(srst[1]),
        .cfgValid(cfg_valid[1]), .cfgBaseAddr(cfg_base[1]), .cfgOpts(cfg_opts[1]), .cfgStop(cfg_stop[1]),
        .streamValid(stream_valid[1]), .streamData(stream_data[1]), .streamEos(stream_eos[1]),
        .streamStop(stream_stop[1]),
        .burstValid(burst_valid[1]), .burstAddr(burst_addr[1]), .burstLen(burst_len[1]),
        .burstOpts(burst_opts[1]), .burstStop(burst_stop[1]),
        .writeValid(write_valid[1]), .writeData(write_data[1]), .writeStop(write_stop[1]),
        .doneValid(done_valid[1]), .doneStatusOk(done_ok[1]), .doneStop(done_stop[1]),
        .resultValid(result_valid[1]), .resultStatusOk(result_ok[1]), .resultWords(result_words[1]),
        .resultStop(result_stop[1])
    );

    int vectors      = 0;
    int miscompares  = 0;
    int cyc          = 0;
    int cur          = 0;
    int out_model    = 0;
    int results_seen = 0;
    int bursts_seen  = 0;
    bit bp_en        = 1'b0;

    logic [63:0] exp_addr_q [$];
    logic [31:0] exp_len_q  [$];
    logic [7:0]  exp_opts_q [$];
    logic [63:0] exp_data_q [$];
    logic [32:0] exp_res_q  [$];
    int          plan_delay_q [$];
    logic        plan_ok_q    [$];
    int          pend_due_q   [$];
    logic        pend_ok_q    [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] word_of(input int tid, input int i);
        return {16'hC0DE, 16'(tid), (32'(i) + 32'd1) * 32'h9E37_79B9};
    endfunction

    function automatic int max_out(input int k);
        return (k == 0) ? 1 : 15;
    endfunction

    // Writer model: returns one completion per issued burst after a planned delay.
    initial begin : responder
        for (int k = 0; k < 2; k++) begin
            done_valid[k] = 1'b0; done_ok[k] = 1'b0;
            burst_stop[k] = 1'b0; write_stop[k] = 1'b0; result_stop[k] = 1'b0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                done_valid[k] = 1'b0; done_ok[k] = 1'b0;
                burst_stop[k] = 1'b0; write_stop[k] = 1'b0; result_stop[k] = 1'b0;
            end
            if (bp_en) begin
                burst_stop[cur]  = ($urandom_range(0, 2) == 0);
                write_stop[cur]  = ($urandom_range(0, 2) == 0);
                result_stop[cur] = ($urandom_range(0, 1) == 0);
            end
            if (pend_due_q.size() != 0 && pend_due_q[0] <= cyc) begin
                done_valid[cur] = 1'b1;
                done_ok[cur]    = pend_ok_q.pop_front();
                void'(pend_due_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin : monitor
        int   d;
        logic ok;
        bit   take;
        if (srst[cur]) begin
            take = done_valid[cur] && (out_model > 0);
            if (burst_valid[cur] && !burst_stop[cur]) begin
                check("burst_within_outstanding_limit", 64'(out_model < max_out(cur)), 64'd1);
                check("burst_expected", 64'(exp_addr_q.size() > 0), 64'd1);
                if (exp_addr_q.size() > 0) begin
                    check("burst_addr", burst_addr[cur], exp_addr_q.pop_front());
                    check("burst_len",  64'(burst_len[cur]), 64'(exp_len_q.pop_front()));
                    check("burst_opts", 64'(burst_opts[cur]), 64'(exp_opts_q.pop_front()));
                end
                bursts_seen++;
                out_model++;
                d  = 3;
                ok = 1'b1;
                if (plan_delay_q.size() != 0) begin
                    d  = plan_delay_q.pop_front();
                    ok = plan_ok_q.pop_front();
                end
                pend_due_q.push_back(cyc + d);
                pend_ok_q.push_back(ok);
            end
            if (write_valid[cur] && !write_stop[cur]) begin
                check("write_expected", 64'(exp_data_q.size() > 0), 64'd1);
                if (exp_data_q.size() > 0) check("write_data", write_data[cur], exp_data_q.pop_front());
            end
            if (take) out_model--;
            if (result_valid[cur] && !result_stop[cur]) begin
                check("result_expected", 64'(exp_res_q.size() > 0), 64'd1);
                if (exp_res_q.size() > 0) begin
                    logic [32:0] r;
                    r = exp_res_q.pop_front();
                    check("result_status_ok", 64'(result_ok[cur]), 64'(r[32]));
                    check("result_words", 64'(result_words[cur]), 64'(r[31:0]));
                end
                results_seen++;
            end
        end
    end

    task automatic expect_burst(input logic [63:0] addr, input logic [31:0] len, input logic [7:0] opts);
        exp_addr_q.push_back(addr);
        exp_len_q.push_back(len);
        exp_opts_q.push_back(opts);
    endtask

    task automatic expect_result(input logic ok, input logic [31:0] words);
        exp_res_q.push_back({ok, words});
    endtask

    // All driving tasks start and end at #1 after a rising edge.
    task automatic send_cfg(input logic [63:0] base, input logic [7:0] opts);
        bit stop;
        int n = 0;
        cfg_valid[cur] = 1'b1; cfg_base[cur] = base; cfg_opts[cur] = opts;
        do begin
            @(negedge clk); stop = cfg_stop[cur];
            @(posedge clk); #1; n++;
        end while (stop && n < 200);
        cfg_valid[cur] = 1'b0;
        check("cfg_accepted", 64'(!stop), 64'd1);
    endtask

    task automatic send_stream(input int n_words, input int tid, input bit eos_last);
        bit stop;
        int n;
        for (int i = 0; i < n_words; i++) begin
            stream_valid[cur] = 1'b1;
            stream_data[cur]  = word_of(tid, i);
            stream_eos[cur]   = eos_last && (i == n_words - 1);
            exp_data_q.push_back(word_of(tid, i));
            n = 0;
            do begin
                @(negedge clk); stop = stream_stop[cur];
                @(posedge clk); #1; n++;
            end while (stop && n < 2000);
            if (stop) begin
                check("stream_word_accepted", 64'(!stop), 64'd1);
                break;
            end
        end
        stream_valid[cur] = 1'b0;
        stream_eos[cur]   = 1'b0;
    endtask

    task automatic wait_result(input string name, input int target, input int budget);
        int n = 0;
        while (results_seen < target && n < budget) begin
            @(posedge clk); n++;
        end
        check({name, "_result_seen"}, 64'(results_seen >= target), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        check({name, "_unconsumed"}, 64'(exp_addr_q.size() + exp_data_q.size() + exp_res_q.size()), 64'd0);
    endtask

    task automatic check_reset(input int k, input string tag);
        check({tag, "_cfgStop"},        64'(cfg_stop[k]),     64'd0);
        check({tag, "_streamStop"},     64'(stream_stop[k]),  64'd1);
        check({tag, "_burstValid"},     64'(burst_valid[k]),  64'd0);
        check({tag, "_writeValid"},     64'(write_valid[k]),  64'd0);
        check({tag, "_doneStop"},       64'(done_stop[k]),    64'd0);
        check({tag, "_resultValid"},    64'(result_valid[k]), 64'd0);
        check({tag, "_burstAddr"},      burst_addr[k],        64'd0);
        check({tag, "_burstLen"},       64'(burst_len[k]),    64'd0);
        check({tag, "_burstOpts"},      64'(burst_opts[k]),   64'd0);
        check({tag, "_writeData"},      write_data[k],        64'd0);
        check({tag, "_resultStatusOk"}, 64'(result_ok[k]),    64'd0);
        check({tag, "_resultWords"},    64'(result_words[k]), 64'd0);
    endtask

    initial begin : stimulus
        int base_bursts;
        int n;
        for (int k = 0; k < 2; k++) begin
            srst[k] = 1'b0; cfg_valid[k] = 1'b0; cfg_base[k] = '0; cfg_opts[k] = '0;
            stream_valid[k] = 1'b0; stream_data[k] = '0; stream_eos[k] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        check_reset(0, "rst_small");
        check_reset(1, "rst_large");
        srst[0] = 1'b1; srst[1] = 1'b1;
        @(posedge clk); #1;

        // 10 words, bursts of 4/4/2
        cur = 0;
        expect_burst(64'h1000, 4, 8'h5A);
        expect_burst(64'h1020, 4, 8'h5A);
        expect_burst(64'h1040, 2, 8'h5A);
        expect_result(1'b1, 32'd10);
        send_cfg(64'h1000, 8'h5A);
        send_stream(10, 1, 1'b1);
        wait_result("t1", 1, 500);

        // single word, unaligned base
        expect_burst(64'h2000, 1, 8'h11);
        expect_result(1'b1, 32'd1);
        send_cfg(64'h2007, 8'h11);
        send_stream(1, 2, 1'b1);
        wait_result("t2", 2, 200);

        // second completion reports an error
        plan_delay_q.push_back(3); plan_ok_q.push_back(1'b1);
        plan_delay_q.push_back(3); plan_ok_q.push_back(1'b0);
        expect_burst(64'h3000, 4, 8'h33);
        expect_burst(64'h3020, 4, 8'h33);
        expect_result(1'b0, 32'd8);
        send_cfg(64'h3000, 8'h33);
        send_stream(8, 3, 1'b1);
        wait_result("t3", 3, 300);

        // first completion withheld: second burst must wait
        plan_delay_q.push_back(50); plan_ok_q.push_back(1'b1);
        base_bursts = bursts_seen;
        expect_burst(64'h4000, 4, 8'h44);
        expect_burst(64'h4020, 4, 8'h44);
        expect_result(1'b1, 32'd8);
        send_cfg(64'h4000, 8'h44);
        send_stream(8, 4, 1'b1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("t4_second_burst_blocked", 64'(burst_valid[0]), 64'd0);
        check("t4_bursts_issued", 64'(bursts_seen - base_bursts), 64'd1);
        @(posedge clk); #1;
        wait_result("t4", 4, 300);

        // 300 words with random back-pressure on the large instance
        cur = 1;
        bp_en = 1'b1;
        expect_burst(64'h10000, 256, 8'hA5);
        expect_burst(64'h10800, 44, 8'hA5);
        expect_result(1'b1, 32'd300);
        send_cfg(64'h10000, 8'hA5);
        send_stream(300, 5, 1'b1);
        wait_result("t5", 5, 5000);
        bp_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // reset in the middle of Drain, then a stale done, then a clean stream
        cur = 0;
        expect_burst(64'h5000, 4, 8'h66);
        send_cfg(64'h5000, 8'h66);
        send_stream(4, 6, 1'b0);
        n = 0;
        while (!write_valid[0] && n < 50) begin
            @(negedge clk); n++;
        end
        @(posedge clk); #1;
        check("t6_in_drain", 64'(write_valid[0]), 64'd1);
        srst[0] = 1'b0;
        exp_addr_q.delete(); exp_len_q.delete(); exp_opts_q.delete();
        exp_data_q.delete(); exp_res_q.delete();
        pend_due_q.delete(); pend_ok_q.delete();
        out_model = 0;
        @(posedge clk); #1;
        check_reset(0, "t6_rst");
        srst[0] = 1'b1;
        pend_due_q.push_back(cyc + 1);
        pend_ok_q.push_back(1'b0);
        expect_burst(64'h6000, 4, 8'h77);
        expect_burst(64'h6020, 1, 8'h77);
        expect_result(1'b1, 32'd5);
        send_cfg(64'h6000, 8'h77);
        send_stream(5, 7, 1'b1);
        wait_result("t6", 6, 300);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
